// File: rtl/pc_unit_ras.sv
// pc_unit_ras
//   Fetch-stage program counter with a circular return-address stack (RAS).
//   curr_pc is registered; nxt_pc is the combinational next value built from
//   the same-cycle control inputs. Fixed priority, highest first:
//   trap, EX redirect, stall, call, ret, sequential increment.
//   A call and a ret in the same cycle behave as a call.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   stall             hold curr_pc; no RAS push or pop
//   trap              go to TRAP_VECTOR and empty the RAS
//   redirect_valid    EX-stage resolution, target is redirect_target (aligned)
//   call/call_target  push curr_pc+INC, go to call_target (aligned)
//   ret               pop the RAS top and go there (sequential PC when empty)
//   curr_pc, nxt_pc   registered PC and its combinational next value
//   pc_valid          low during reset and the first cycle after it
//   ras_count         number of valid RAS entries, 0..RAS_DEPTH
//   ras_overflow      one-cycle pulse after a push into a full RAS
//   ras_underflow     one-cycle pulse after a ret on an empty RAS
//
// Handshake: none. Every control input is sampled on each rising clk edge
// while reset is low. There is no valid/ready pair; stall is the only
// back-pressure, and it masks call and ret for that cycle.
module pc_unit_ras #(
  parameter int unsigned XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned INC          = 4,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         trap,
  input  logic                         redirect_valid,
  input  logic [XLEN-1:0]              redirect_target,
  input  logic                         call,
  input  logic [XLEN-1:0]              call_target,
  input  logic                         ret,
  output logic [XLEN-1:0]              curr_pc,
  output logic [XLEN-1:0]              nxt_pc,
  output logic                         pc_valid,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  // Clears the low log2(INC) bits of a target address.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INC - 1));

  // ras_ptr is the next free slot; the stack top sits at ras_ptr-1.
  // When the stack is full, ras_ptr points at the oldest entry, so a push
  // naturally overwrites it.
  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   ras_ptr;
  logic            valid_stage;

  logic [XLEN-1:0] seq_pc;
  logic [PW-1:0]   top_idx;
  logic            ras_full;
  logic            ras_empty;
  logic            do_push;
  logic            do_pop;
  logic            do_clear;
  logic            do_uflow;

  assign seq_pc    = curr_pc + XLEN'(INC);
  assign top_idx   = ras_ptr - PW'(1);
  assign ras_full  = (ras_count == CW'(RAS_DEPTH));
  assign ras_empty = (ras_count == '0);

  always_comb begin
    nxt_pc   = seq_pc;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    do_clear = 1'b0;
    do_uflow = 1'b0;
    if (reset) begin
      nxt_pc = RESET_VECTOR;
    end else if (trap) begin
      nxt_pc   = TRAP_VECTOR;
      do_clear = 1'b1;
    end else if (redirect_valid) begin
      nxt_pc = redirect_target & ALIGN_MASK;
    end else if (stall) begin
      nxt_pc = curr_pc;
    end else if (call) begin
      nxt_pc  = call_target & ALIGN_MASK;
      do_push = 1'b1;
    end else if (ret) begin
      if (!ras_empty) begin
        nxt_pc = ras_mem[top_idx];
        do_pop = 1'b1;
      end else begin
        do_uflow = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      curr_pc       <= RESET_VECTOR;
      ras_ptr       <= '0;
      ras_count     <= '0;
      valid_stage   <= 1'b0;
      pc_valid      <= 1'b0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      curr_pc       <= nxt_pc;
      // Two-stage so pc_valid rises on the second edge after reset release.
      valid_stage   <= 1'b1;
      pc_valid      <= valid_stage;
      ras_overflow  <= do_push & ras_full;
      ras_underflow <= do_uflow;
      if (do_clear) begin
        ras_ptr   <= '0;
        ras_count <= '0;
      end else if (do_push) begin
        ras_ptr <= ras_ptr + PW'(1);
        if (!ras_full) begin
          ras_count <= ras_count + CW'(1);
        end
      end else if (do_pop) begin
        ras_ptr   <= top_idx;
        ras_count <= ras_count - CW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only read while ras_count says they
  // are valid, and do_push is never set while reset is high.
  always_ff @(posedge clk) begin
    if (do_push) begin
      ras_mem[ras_ptr] <= seq_pc;
    end
  end

endmodule
